qsystd_timer_ctl_master: RTL and testbench
==========================================

// Module: qsystd_timer_ctl_master
// PURPOSE
//  Avalon-MM initiator that programs, runs and services the 16-bit-register interval timer slave.
//  Accepts a one-shot/continuous command, writes period and control, and counts timeouts via irq.
//  Acknowledges each timeout and reads the 32-bit snapshot on request.
//  Sits between on-chip control logic and the timer's s1 slave port; no CPU required.
// PARAMETERS
//  TICK_W   16  width of tick_count (wraps modulo 2^TICK_W)
//  ABORT_CTL 8  control word written on abort (stop=1, cont=0, ito=0)
// PORTS
//  clk           in   1   system clock
//  reset_n       in   1   asynchronous active-low reset
//  cmd_valid     in   1   command request
//  cmd_ready     out  1   high only in IDLE; command accepted when cmd_valid&&cmd_ready
//  cmd_period    in   32  timer period (timer counts cmd_period+1 clocks per timeout)
//  cmd_continuous in  1   1=continuous, 0=single timeout then IDLE
//  snap_req      in   1   level request for a counter snapshot, sampled in RUN
//  abort         in   1   stop timer and return to IDLE
//  busy          out  1   state != IDLE
//  tick_count    out  TICK_W timeouts serviced since last accepted command
//  snap_valid    out  1   one-cycle pulse, snap_value updated
//  snap_value    out  32  last snapshot {high,low}
//  m_address     out  3   timer register address
//  m_chipselect  out  1   timer chipselect
//  m_write_n     out  1   timer write strobe, active low
//  m_writedata   out  16  timer write data
//  m_readdata    in   16  timer read data, valid 1 clk after address presented (fixed latency 1)
//  irq           in   1   timer interrupt (timeout_occurred && ito)
// BEHAVIOUR
//  Reset: state=IDLE, m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, tick_count=0,
//   snap_value=0, snap_valid=0, busy=0, cmd_ready=1. All outputs registered.
//  Every state lasts exactly 1 clk; slave has no waitrequest. Bus idle: cs=0, write_n=1.
//  Write states (cs=1, write_n=0):
//   W_STOP  addr1 data 0x0008     W_PL addr2 data period[15:0]   W_PH addr3 data period[31:16]
//   W_CTRL  addr1 data 0x0005|cont<<1 (start, ito=1)   W_ACK addr0 data 0   W_SNAP addr4 data 0
//   W_ABORT addr1 data ABORT_CTL
//  Read states (cs=1, write_n=1): R_SL addr4; R_SH addr5, capture m_readdata as low half;
//   R_CAP bus idle, capture high half, pulse snap_valid, snap_value={high,low} in same cycle.
//  Transitions: IDLE --accept--> W_STOP->W_PL->W_PH->W_CTRL->RUN; command fields latched and
//   tick_count cleared on accept. Period writes force-reload the timer; start follows them.
//  RUN: irq=1 -> W_ACK (priority); else snap_req=1 -> W_SNAP->R_SL->R_SH->R_CAP->RUN.
//  W_ACK: tick_count+=1 (wraps); next RUN if continuous, else IDLE.
//   irq falls the cycle after W_ACK, so one timeout counts once.
//  abort=1 in any state except IDLE/W_ABORT: next state W_ABORT, then IDLE; overrides irq/snap.
//   Abort during snapshot sequence: snap_valid not pulsed, snap_value unchanged.
//  abort in IDLE ignored; cmd_valid outside IDLE ignored (not accepted, not queued).
//  Timeout coinciding with W_ACK write is lost (slave clear wins); documented, not corrected.
//  Single-shot: timer stops itself at zero; block leaves it stopped, no W_STOP on exit.
//  Reset mid-sequence: immediate return to IDLE, bus idle; timer state not cleaned up.
// TESTING
//  1 cmd period=0x0001_86A0 cont=0 -> writes (1,0x8),(2,0x86A0),(3,0x0001),(1,0x5) in 4 clks;
//    after irq: (0,0x0000), tick_count=1, IDLE.
//  2 cont=1, period=9, timer model -> tick_count=3 after 30 clks of running plus ack cycles;
//    busy stays 1.
//  3 RUN, snap_req, model counter=0x0012_3456 -> W_SNAP, R_SL, R_SH, R_CAP;
//    snap_value=0x00123456, snap_valid 1 clk.
//  4 irq and snap_req same cycle in RUN -> W_ACK first, then snapshot sequence.
//  5 abort during R_SH -> W_ABORT writes (1,0x0008), IDLE next; snap_valid never asserted.
//  6 reset_n low mid W_PL -> outputs at reset values asynchronously;
//    cmd_ready=1 on first clk after release.

Source files
------------

// File: rtl/qsystd_timer_ctl_master.sv
// Avalon-MM initiator that programs, runs, acknowledges and snapshots an interval timer slave.
// Every state is one clock; bus strobes are registered from the next state so they line up with it.
module qsystd_timer_ctl_master #(
  parameter int          TICK_W    = 16,
  parameter logic [15:0] ABORT_CTL = 16'h0008
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [31:0]       cmd_period,
  input  logic              cmd_continuous,
  input  logic              snap_req,
  input  logic              abort,
  output logic              busy,
  output logic [TICK_W-1:0] tick_count,
  output logic              snap_valid,
  output logic [31:0]       snap_value,
  output logic [2:0]        m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [15:0]       m_writedata,
  input  logic [15:0]       m_readdata,
  input  logic              irq
);

  typedef enum logic [3:0] {
    IDLE, W_STOP, W_PL, W_PH, W_CTRL, RUN, W_ACK,
    W_SNAP, R_SL, R_SH, R_CAP, W_ABORT
  } state_t;

  state_t      state, nxt;
  logic [31:0] period_q;
  logic        cont_q;
  logic [15:0] snap_lo;
  logic        accept;
  logic        bus_cs, bus_wn;
  logic [2:0]  bus_addr;
  logic [15:0] bus_wd;

  assign accept = cmd_valid && cmd_ready;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = W_STOP;
      W_STOP:  nxt = W_PL;
      W_PL:    nxt = W_PH;
      W_PH:    nxt = W_CTRL;
      W_CTRL:  nxt = RUN;
      RUN:     if (irq) nxt = W_ACK;
               else if (snap_req) nxt = W_SNAP;
      W_ACK:   nxt = cont_q ? RUN : IDLE;
      W_SNAP:  nxt = R_SL;
      R_SL:    nxt = R_SH;
      R_SH:    nxt = R_CAP;
      R_CAP:   nxt = RUN;
      W_ABORT: nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // abort wins over irq and snapshot from any active state
    if (abort && state != IDLE && state != W_ABORT) nxt = W_ABORT;
  end

  // Bus pattern for the state being entered; period/cont are already latched by W_PL.
  always_comb begin
    bus_cs   = 1'b1;
    bus_wn   = 1'b0;
    bus_addr = 3'd0;
    bus_wd   = 16'h0000;
    case (nxt)
      W_STOP:  begin bus_addr = 3'd1; bus_wd = 16'h0008; end
      W_PL:    begin bus_addr = 3'd2; bus_wd = period_q[15:0]; end
      W_PH:    begin bus_addr = 3'd3; bus_wd = period_q[31:16]; end
      W_CTRL:  begin bus_addr = 3'd1; bus_wd = {14'h0, cont_q, 1'b0} | 16'h0005; end
      W_ACK:   bus_addr = 3'd0;
      W_SNAP:  bus_addr = 3'd4;
      W_ABORT: begin bus_addr = 3'd1; bus_wd = ABORT_CTL; end
      R_SL:    begin bus_addr = 3'd4; bus_wn = 1'b1; end
      R_SH:    begin bus_addr = 3'd5; bus_wn = 1'b1; end
      default: begin bus_cs = 1'b0; bus_wn = 1'b1; end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_address    <= 3'd0;
      m_writedata  <= 16'h0000;
      period_q     <= 32'h0;
      cont_q       <= 1'b0;
      tick_count   <= '0;
      snap_lo      <= 16'h0000;
      snap_value   <= 32'h0;
      snap_valid   <= 1'b0;
    end else begin
      state        <= nxt;
      cmd_ready    <= (nxt == IDLE);
      busy         <= (nxt != IDLE);
      m_chipselect <= bus_cs;
      m_write_n    <= bus_wn;
      m_address    <= bus_addr;
      m_writedata  <= bus_wd;
      snap_valid   <= 1'b0;
      if (accept) begin
        period_q   <= cmd_period;
        cont_q     <= cmd_continuous;
        tick_count <= '0;
      end
      if (state == W_ACK && nxt != W_ABORT) tick_count <= tick_count + 1'b1;
      // read data trails the address by one clock
      if (state == R_SH && nxt == R_CAP) snap_lo <= m_readdata;
      if (state == R_CAP && nxt == RUN) begin
        snap_value <= {m_readdata, snap_lo};
        snap_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qsystd_timer_ctl_master.sv
// Directed bench: behavioural interval-timer slave plus a linear sequence of checked steps.
module tb_qsystd_timer_ctl_master;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_continuous = 1'b0, snap_req = 1'b0, abort = 1'b0;
  logic [31:0] cmd_period = 32'h0;
  logic        cmd_ready, busy, snap_valid, m_chipselect, m_write_n, irq;
  logic [15:0] tick_count, m_writedata, m_readdata;
  logic [31:0] snap_value;
  logic [2:0]  m_address;

  int checks = 0, failures = 0;
  int n;

  // timer slave model
  logic [31:0] tm_per, tm_cnt, tm_snap, force_val;
  logic        tm_run, tm_cont, tm_ito, tm_to, cnt_jump, force_snap;
  initial begin cnt_jump = 1'b0; force_snap = 1'b0; force_val = 32'h0; end

  qsystd_timer_ctl_master dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_period(cmd_period), .cmd_continuous(cmd_continuous), .snap_req(snap_req),
    .abort(abort), .busy(busy), .tick_count(tick_count), .snap_valid(snap_valid),
    .snap_value(snap_value), .m_address(m_address), .m_chipselect(m_chipselect),
    .m_write_n(m_write_n), .m_writedata(m_writedata), .m_readdata(m_readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  assign irq = tm_to && tm_ito;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tm_per <= 0; tm_cnt <= 0; tm_snap <= 0; tm_run <= 0; tm_cont <= 0;
      tm_ito <= 0; tm_to <= 0; m_readdata <= 0;
    end else begin
      if (cnt_jump) tm_cnt <= 0;
      else if (tm_run) begin
        if (tm_cnt == 0) begin
          tm_to <= 1'b1; tm_cnt <= tm_per;
          if (!tm_cont) tm_run <= 1'b0;
        end else tm_cnt <= tm_cnt - 1;
      end
      if (m_chipselect && !m_write_n) begin
        case (m_address)
          3'd0: tm_to <= 1'b0;
          3'd1: begin
            tm_ito <= m_writedata[0]; tm_cont <= m_writedata[1];
            if (m_writedata[2]) tm_run <= 1'b1;
            if (m_writedata[3]) tm_run <= 1'b0;
          end
          3'd2: begin tm_per[15:0] <= m_writedata; tm_cnt <= {tm_per[31:16], m_writedata}; tm_run <= 0; end
          3'd3: begin tm_per[31:16] <= m_writedata; tm_cnt <= {m_writedata, tm_per[15:0]}; tm_run <= 0; end
          3'd4: tm_snap <= force_snap ? force_val : tm_cnt;
          default: ;
        endcase
      end
      m_readdata <= (m_chipselect && m_write_n) ?
                    ((m_address == 3'd4) ? tm_snap[15:0] :
                     (m_address == 3'd5) ? tm_snap[31:16] : 16'h0) : 16'h0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {cs, write_n, addr, data}
  function automatic logic [31:0] bus(input logic cs, input logic wn, input logic [2:0] a,
                                      input logic [15:0] d);
    return {11'h0, cs, wn, a, d};
  endfunction

  function automatic logic [31:0] bus_now();
    return {11'h0, m_chipselect, m_write_n, m_address, m_writedata};
  endfunction

  // Issue a command and stop on the first RUN cycle.
  task automatic start_cmd(input logic [31:0] per, input logic cont);
    cmd_period = per; cmd_continuous = cont; cmd_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_bus", bus_now(), bus(0, 1, 0, 0));
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tick", tick_count, 0);
    chk("rst_snap", {snap_valid, snap_value}, 0);

    // abort in IDLE ignored
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("idle_abort", {cmd_ready, busy, bus_now()}, {2'b10, bus(0, 1, 0, 0)});

    // 1: single-shot program sequence and ack
    cmd_period = 32'h0001_86A0; cmd_continuous = 1'b0; cmd_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    chk("t1_stop", bus_now(), bus(1, 0, 1, 16'h0008));
    @(negedge clk); chk("t1_pl", bus_now(), bus(1, 0, 2, 16'h86A0));
    @(negedge clk); chk("t1_ph", bus_now(), bus(1, 0, 3, 16'h0001));
    @(negedge clk); chk("t1_ctrl", bus_now(), bus(1, 0, 1, 16'h0005));
    @(negedge clk); chk("t1_run", {busy, cmd_ready, bus_now()}, {2'b10, bus(0, 1, 0, 0)});
    cnt_jump = 1'b1; @(negedge clk); cnt_jump = 1'b0;
    n = 0;
    while (!(m_chipselect && !m_write_n && m_address == 3'd0) && n < 10) begin
      @(negedge clk); n++;
    end
    chk("t1_ack", bus_now(), bus(1, 0, 0, 0));
    @(negedge clk);
    chk("t1_done", {cmd_ready, busy, tick_count}, {2'b10, 16'd1});

    // 2: continuous, period 9 -> third ack completes 32 clocks after start
    start_cmd(32'd9, 1'b1);
    n = 0;
    while (tick_count != 16'd3 && n < 100) begin
      @(negedge clk); n++;
      if (busy !== 1'b1) chk("t2_busy", busy, 1);
    end
    chk("t2_cycles", n, 32);
    chk("t2_tick", tick_count, 3);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("t2_abort", bus_now(), bus(1, 0, 1, 16'h0008));
    @(negedge clk); chk("t2_idle", {cmd_ready, busy}, 2'b10);

    // 3: snapshot; a command while busy is ignored
    force_snap = 1'b1; force_val = 32'h0012_3456;
    start_cmd(32'h0000_FFFF, 1'b1);
    cmd_valid = 1'b1; @(negedge clk); cmd_valid = 1'b0;
    chk("t3_cmd_ign", {busy, cmd_ready, bus_now()}, {2'b10, bus(0, 1, 0, 0)});
    snap_req = 1'b1; @(negedge clk); snap_req = 1'b0;
    chk("t3_wsnap", bus_now(), bus(1, 0, 4, 0));
    @(negedge clk); chk("t3_rsl", bus_now(), bus(1, 1, 4, 0));
    @(negedge clk); chk("t3_rsh", bus_now(), bus(1, 1, 5, 0));
    @(negedge clk); chk("t3_rcap", {snap_valid, bus_now()}, {1'b0, bus(0, 1, 0, 0)});
    @(negedge clk); chk("t3_valid", {snap_valid, snap_value}, {1'b1, 32'h0012_3456});
    @(negedge clk); chk("t3_pulse", snap_valid, 0);

    // 4: irq and snap_req together -> ack first
    force_val = 32'hABCD_0001;
    cnt_jump = 1'b1; @(negedge clk); cnt_jump = 1'b0;
    n = 0;
    while (!irq && n < 5) begin @(negedge clk); n++; end
    chk("t4_irq", irq, 1);
    snap_req = 1'b1; @(negedge clk);
    chk("t4_ack", bus_now(), bus(1, 0, 0, 0));
    @(negedge clk); chk("t4_run", {tick_count, bus_now()}, {16'd1, bus(0, 1, 0, 0)});
    @(negedge clk); snap_req = 1'b0;
    chk("t4_wsnap", bus_now(), bus(1, 0, 4, 0));
    repeat (4) @(negedge clk);
    chk("t4_snap", {snap_valid, snap_value}, {1'b1, 32'hABCD_0001});

    // 5: abort during R_SH
    force_val = 32'h5555_AAAA;
    snap_req = 1'b1; @(negedge clk); snap_req = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("t5_rsh", bus_now(), bus(1, 1, 5, 0));
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("t5_abort", {snap_valid, bus_now()}, {1'b0, bus(1, 0, 1, 16'h0008)});
    @(negedge clk);
    chk("t5_idle", {cmd_ready, busy, snap_valid}, 3'b100);
    chk("t5_value", snap_value, 32'hABCD_0001);
    @(negedge clk); chk("t5_novalid", snap_valid, 0);

    // 6: asynchronous reset in W_PL
    cmd_period = 32'h0003_0004; cmd_continuous = 1'b0; cmd_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk); chk("t6_pl", bus_now(), bus(1, 0, 2, 16'h0004));
    #2 reset_n = 1'b0;
    #1 chk("t6_rst_bus", bus_now(), bus(0, 1, 0, 0));
    chk("t6_rst_st", {cmd_ready, busy, snap_valid, tick_count}, {3'b100, 16'd0});
    chk("t6_rst_val", snap_value, 0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    chk("t6_release", {cmd_ready, busy, bus_now()}, {2'b10, bus(0, 1, 0, 0)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
